// File: rtl/agu0_issue_arbiter_pkg.sv
// Shared types for the AGU0 issue path: request payload, op encoding and arbiter state.
package agu_pkg;

  // Field order matches AGU0's skid buffer so the payload can be passed through as one vector.
  typedef struct packed {
    logic [5:0]  rob;
    logic [3:0]  op;
    logic [31:0] data;
    logic [31:0] addr;
    logic [5:0]  dest;
  } agu_req_t;

  localparam int OP_STORE_BIT = 3;

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_A = 1'b1
  } arb_state_e;

endpackage

// File: rtl/agu_arb_starve.sv
// Winner select for the AGU0 arbiter: replay queue (B) has priority unless
// the issue queue (A) has been starved for STARVE_LIMIT consecutive B grants.
module agu_arb_starve
  import agu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic cpu_clock_i,
  input  logic cpu_reset_i,
  input  logic flush_i,
  input  logic slot_free,
  input  logic a_vld,
  input  logic b_vld,
  output logic sel_b,
  output logic sel_vld
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e state_q;
  logic [3:0] starve_q;
  logic [3:0] starve_inc;
  logic       grant;

  always_comb begin
    sel_vld    = a_vld | b_vld;
    sel_b      = (state_q == NORMAL) ? b_vld : (b_vld & ~a_vld);
    grant      = slot_free & ~flush_i & sel_vld;
    starve_inc = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
  end

  // A B grant can only occur with A waiting while in NORMAL, so the FORCE_A
  // entry is evaluated on the incremented count of that grant.
  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      starve_q <= 4'd0;
      state_q  <= NORMAL;
    end else if (flush_i || !a_vld || (grant && !sel_b)) begin
      starve_q <= 4'd0;
      state_q  <= NORMAL;
    end else if (grant) begin
      starve_q <= starve_inc;
      if (starve_inc == LIMIT) state_q <= FORCE_A;
    end
  end

endmodule

// File: rtl/agu0_issue_arbiter.sv
// Two-requester arbiter and registered issue slot in front of the AGU0 memory pipe.
// Holds the issued request bit-stable while AGU0 applies back-pressure.
module agu0_issue_arbiter
  import agu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_i,
  input  logic        flush_i,
  input  logic        a_vld_i,
  input  logic [5:0]  a_rob_i,
  input  logic [3:0]  a_op_i,
  input  logic [31:0] a_data_i,
  input  logic [31:0] a_addr_i,
  input  logic [5:0]  a_dest_i,
  output logic        a_busy_o,
  input  logic        b_vld_i,
  input  logic [5:0]  b_rob_i,
  input  logic [3:0]  b_op_i,
  input  logic [31:0] b_data_i,
  input  logic [31:0] b_addr_i,
  input  logic [5:0]  b_dest_i,
  output logic        b_busy_o,
  output logic        lsu_vld_o,
  output logic [5:0]  lsu_rob_o,
  output logic [3:0]  lsu_op_o,
  output logic [31:0] lsu_data_o,
  output logic [31:0] lsu_addr_o,
  output logic [5:0]  lsu_dest_o,
  input  logic        agu_busy_i,
  output logic        grant_b_o
);

  agu_req_t a_req;
  agu_req_t b_req;
  agu_req_t lsu_q;
  logic     lsu_vld_q;
  logic     grant_b_q;
  logic     slot_free;
  logic     sel_b;
  logic     sel_vld;

  assign a_req     = {a_rob_i, a_op_i, a_data_i, a_addr_i, a_dest_i};
  assign b_req     = {b_rob_i, b_op_i, b_data_i, b_addr_i, b_dest_i};
  assign slot_free = ~lsu_vld_q | ~agu_busy_i;

  agu_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .cpu_clock_i(cpu_clock_i),
    .cpu_reset_i(cpu_reset_i),
    .flush_i    (flush_i),
    .slot_free  (slot_free),
    .a_vld      (a_vld_i),
    .b_vld      (b_vld_i),
    .sel_b      (sel_b),
    .sel_vld    (sel_vld)
  );

  // sel_vld is implied whenever the busy term's own valid is set.
  assign a_busy_o = cpu_reset_i | flush_i | ~slot_free | (a_vld_i & sel_b);
  assign b_busy_o = cpu_reset_i | flush_i | ~slot_free | (b_vld_i & ~sel_b);

  // Flush drops the slot even under back-pressure; AGU0 flushes its own copy.
  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      lsu_q     <= '0;
      lsu_vld_q <= 1'b0;
      grant_b_q <= 1'b0;
    end else if (flush_i) begin
      lsu_vld_q <= 1'b0;
      grant_b_q <= 1'b0;
    end else if (slot_free) begin
      if (sel_vld) begin
        lsu_q     <= sel_b ? b_req : a_req;
        lsu_vld_q <= 1'b1;
        grant_b_q <= sel_b;
      end else begin
        lsu_vld_q <= 1'b0;
      end
    end
  end

  assign lsu_vld_o  = lsu_vld_q;
  assign lsu_rob_o  = lsu_q.rob;
  assign lsu_op_o   = lsu_q.op;
  assign lsu_data_o = lsu_q.data;
  assign lsu_addr_o = lsu_q.addr;
  assign lsu_dest_o = lsu_q.dest;
  assign grant_b_o  = grant_b_q;

endmodule

// File: tb/tb_agu0_issue_arbiter.sv
// Scoreboard bench for agu0_issue_arbiter: directed requester queues, expected
// retire order pushed by the stimulus, checked by an independent monitor.
module tb_agu0_issue_arbiter;
  import agu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        a_vld_i = 1'b0, b_vld_i = 1'b0;
  logic [5:0]  a_rob_i = '0, b_rob_i = '0, a_dest_i = '0, b_dest_i = '0;
  logic [3:0]  a_op_i = '0, b_op_i = '0;
  logic [31:0] a_data_i = '0, b_data_i = '0, a_addr_i = '0, b_addr_i = '0;
  logic        a_busy_o, b_busy_o, lsu_vld_o, grant_b_o;
  logic [5:0]  lsu_rob_o, lsu_dest_o;
  logic [3:0]  lsu_op_o;
  logic [31:0] lsu_data_o, lsu_addr_o;
  logic        agu_busy_i = 1'b0;

  agu0_issue_arbiter #(.STARVE_LIMIT(4)) u_dut (
    .cpu_clock_i(clk), .cpu_reset_i(rst), .flush_i(flush_i),
    .a_vld_i(a_vld_i), .a_rob_i(a_rob_i), .a_op_i(a_op_i), .a_data_i(a_data_i),
    .a_addr_i(a_addr_i), .a_dest_i(a_dest_i), .a_busy_o(a_busy_o),
    .b_vld_i(b_vld_i), .b_rob_i(b_rob_i), .b_op_i(b_op_i), .b_data_i(b_data_i),
    .b_addr_i(b_addr_i), .b_dest_i(b_dest_i), .b_busy_o(b_busy_o),
    .lsu_vld_o(lsu_vld_o), .lsu_rob_o(lsu_rob_o), .lsu_op_o(lsu_op_o),
    .lsu_data_o(lsu_data_o), .lsu_addr_o(lsu_addr_o), .lsu_dest_o(lsu_dest_o),
    .agu_busy_i(agu_busy_i), .grant_b_o(grant_b_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic     gb;
    agu_req_t req;
  } sb_t;

  sb_t      exp_q[$];
  agu_req_t qa[$];
  agu_req_t qb[$];
  int       n_cmp = 0;
  int       n_bad = 0;
  int       max_starve = 0;

  task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic agu_req_t mk(input logic [5:0] rob, input logic st);
    agu_req_t r;
    r.rob              = rob;
    r.op               = 4'b0010;
    r.op[OP_STORE_BIT] = st;
    r.data             = 32'hD000_0000 | {26'd0, rob};
    r.addr             = 32'h0000_2000 + {24'd0, rob, 2'b00};
    r.dest             = ~rob;
    return r;
  endfunction

  task automatic expect_req(input agu_req_t r, input logic gb);
    sb_t e;
    e.gb  = gb;
    e.req = r;
    exp_q.push_back(e);
  endtask

  task automatic drive_inputs();
    agu_req_t ra, rb;
    ra = (qa.size() > 0) ? qa[0] : '0;
    rb = (qb.size() > 0) ? qb[0] : '0;
    a_vld_i = (qa.size() > 0);
    b_vld_i = (qb.size() > 0);
    {a_rob_i, a_op_i, a_data_i, a_addr_i, a_dest_i} = ra;
    {b_rob_i, b_op_i, b_data_i, b_addr_i, b_dest_i} = rb;
  endtask

  // Requester model: a request leaves its queue only when seen accepted.
  initial begin
    logic acc_a, acc_b;
    forever begin
      @(negedge clk);
      acc_a = a_vld_i & ~a_busy_o;
      acc_b = b_vld_i & ~b_busy_o;
      @(posedge clk);
      #1;
      if (acc_a && qa.size() > 0) void'(qa.pop_front());
      if (acc_b && qb.size() > 0) void'(qb.pop_front());
      drive_inputs();
    end
  end

  // Monitor: a request retires when valid and not back-pressured.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (u_dut.u_starve.starve_q > 4'(max_starve)) max_starve = int'(u_dut.u_starve.starve_q);
      if (!rst && lsu_vld_o && !agu_busy_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_retire", {1'b1, lsu_rob_o, 74'd0}, 81'd0);
        end else begin
          e = exp_q.pop_front();
          chk("retire", {grant_b_o, lsu_rob_o, lsu_op_o, lsu_data_o, lsu_addr_o, lsu_dest_o}, e);
        end
      end
    end
  end

  task automatic wait_vld();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #2;
      seen = lsu_vld_o;
    end
    chk("wait_vld_timeout", 81'(seen), 81'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", 81'(exp_q.size()), 81'd0);
  endtask

  initial begin
    agu_req_t r;
    // Reset state
    #2;
    chk("rst_vld", 81'(lsu_vld_o), 81'd0);
    chk("rst_gb", 81'(grant_b_o), 81'd0);
    chk("rst_busy", {79'd0, a_busy_o, b_busy_o}, 81'd3);
    chk("rst_fields", {lsu_rob_o, lsu_op_o, lsu_data_o, lsu_addr_o, lsu_dest_o}, 81'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #2;

    // A only, address 0x1000
    r = mk(6'd1, 1'b0);
    r.addr = 32'h0000_1000;
    qa.push_back(r);
    expect_req(r, 1'b0);
    drive_inputs();
    @(negedge clk);
    chk("a_only_busy", 81'(a_busy_o), 81'd0);
    @(posedge clk);
    #2;
    chk("a_only_vld", 81'(lsu_vld_o), 81'd1);
    chk("a_only_addr", 81'(lsu_addr_o), 81'h1000);
    chk("a_only_gb", 81'(grant_b_o), 81'd0);
    wait_drain();

    // A and B together: B first, then A (A carries a store op)
    qa.push_back(mk(6'd2, 1'b1));
    qb.push_back(mk(6'd3, 1'b0));
    expect_req(mk(6'd3, 1'b0), 1'b1);
    expect_req(mk(6'd2, 1'b1), 1'b0);
    drive_inputs();
    @(negedge clk);
    chk("ab_busy", {79'd0, a_busy_o, b_busy_o}, 81'd2);
    wait_drain();

    // Starvation: B,B,B,B,A,B,B,B,B,A,B,B
    max_starve = 0;
    qa.push_back(mk(6'd10, 1'b0));
    qa.push_back(mk(6'd11, 1'b1));
    for (int i = 0; i < 10; i++) qb.push_back(mk(6'(20 + i), 1'b0));
    for (int i = 0; i < 4; i++) expect_req(mk(6'(20 + i), 1'b0), 1'b1);
    expect_req(mk(6'd10, 1'b0), 1'b0);
    for (int i = 4; i < 8; i++) expect_req(mk(6'(20 + i), 1'b0), 1'b1);
    expect_req(mk(6'd11, 1'b1), 1'b0);
    expect_req(mk(6'd28, 1'b0), 1'b1);
    expect_req(mk(6'd29, 1'b0), 1'b1);
    drive_inputs();
    wait_drain();
    chk("starve_max", 81'(max_starve), 81'd4);

    // Back-pressure: held for 3 cycles, then retire and reload in one cycle
    qa.push_back(mk(6'd30, 1'b0));
    qa.push_back(mk(6'd31, 1'b0));
    expect_req(mk(6'd30, 1'b0), 1'b0);
    expect_req(mk(6'd40, 1'b1), 1'b1);
    expect_req(mk(6'd31, 1'b0), 1'b0);
    drive_inputs();
    wait_vld();
    agu_busy_i = 1'b1;
    qb.push_back(mk(6'd40, 1'b1));
    drive_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", {grant_b_o, lsu_rob_o, lsu_op_o, lsu_data_o, lsu_addr_o, lsu_dest_o},
          {1'b0, mk(6'd30, 1'b0)});
      chk("bp_busy", {78'd0, lsu_vld_o, a_busy_o, b_busy_o}, 81'd7);
    end
    @(posedge clk);
    #2 agu_busy_i = 1'b0;
    @(posedge clk);
    #2;
    chk("bp_reload", {79'd0, lsu_vld_o, grant_b_o}, 81'd3);
    chk("bp_reload_rob", 81'(lsu_rob_o), 81'd40);
    wait_drain();

    // Flush under back-pressure; request presented during flush is dropped
    qb.push_back(mk(6'd50, 1'b0));
    drive_inputs();
    wait_vld();
    agu_busy_i = 1'b1;
    @(posedge clk);
    #2;
    flush_i = 1'b1;
    qa.push_back(mk(6'd51, 1'b0));
    drive_inputs();
    @(negedge clk);
    chk("flush_busy", {79'd0, a_busy_o, b_busy_o}, 81'd3);
    @(posedge clk);
    #2;
    flush_i = 1'b0;
    qa.delete();
    drive_inputs();
    @(negedge clk);
    chk("flush_out", {79'd0, lsu_vld_o, grant_b_o}, 81'd0);
    chk("flush_fsm", {76'd0, u_dut.u_starve.state_q, u_dut.u_starve.starve_q}, 81'd0);
    @(posedge clk);
    #2 agu_busy_i = 1'b0;
    wait_drain();

    // Asynchronous reset between edges while holding a request
    qa.push_back(mk(6'd60, 1'b0));
    drive_inputs();
    wait_vld();
    agu_busy_i = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_vld", 81'(lsu_vld_o), 81'd0);
    chk("arst_busy", {79'd0, a_busy_o, b_busy_o}, 81'd3);
    @(posedge clk);
    #2;
    agu_busy_i = 1'b0;
    qa.push_back(mk(6'd61, 1'b1));
    expect_req(mk(6'd61, 1'b1), 1'b0);
    drive_inputs();
    #1 rst = 1'b0;
    @(posedge clk);
    #2;
    chk("arst_first_grant", {74'd0, lsu_vld_o, lsu_rob_o}, {74'd0, 1'b1, 6'd61});
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/agu0_issue_arbiter.md
# agu0_issue_arbiter

Two-requester arbiter and issue register in front of AGU0. It shares the single AGU0 memory pipe between the memory issue queue (port A, new ops) and the load replay queue (port B, loads re-sent after a load/store-queue reject). Port B has fixed priority. A starvation counter forces an A grant after `STARVE_LIMIT` consecutive B grants while A is waiting. Output is a registered 80-bit request that stays stable under AGU0 back-pressure.

## Interface
- `STARVE_LIMIT`, default 4: consecutive B grants allowed while A waits before A is forced; legal range 1..15.

Ports:
- `cpu_clock_i`  in  1  sole clock, rising edge.
- `cpu_reset_i`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  pipeline flush.
- `a_vld_i`  in  1  request from the memory issue queue.
- `a_rob_i`  in  6  ROB tag for A.
- `a_op_i`  in  4  op for A; bit3 = store, bits[2:0] = size/sign.
- `a_data_i`  in  32  store data for A.
- `a_addr_i`  in  32  effective address for A.
- `a_dest_i`  in  6  destination register for A.
- `a_busy_o`  out  1  A not accepted this cycle; A must hold its request.
- `b_vld_i`, `b_rob_i`, `b_op_i`, `b_data_i`, `b_addr_i`, `b_dest_i`  in  1/6/4/32/32/6  same fields for the replay queue.
- `b_busy_o`  out  1  B not accepted this cycle; B must hold its request.
- `lsu_vld_o`  out  1  request valid to AGU0.
- `lsu_rob_o`  out  6  ROB tag to AGU0.
- `lsu_op_o`  out  4  op to AGU0.
- `lsu_data_o`  out  32  store data to AGU0.
- `lsu_addr_o`  out  32  address to AGU0.
- `lsu_dest_o`  out  6  destination register to AGU0.
- `agu_busy_i`  in  1  AGU0 back-pressure (its `lsu_busy_o`).
- `grant_b_o`  out  1  registered; the current `lsu_*_o` request came from B. For performance counters.

## Operation
- **Slot free:** `slot_free = !lsu_vld_o | !agu_busy_i`. A request is accepted only when the slot is free, `flush_i` = 0 and reset is inactive.
- **Grant, state NORMAL:** B wins if `b_vld_i`; otherwise A wins if `a_vld_i`.
- **Grant, state FORCE_A:** A wins if `a_vld_i`; otherwise B wins if `b_vld_i`.
- **Busy outputs (combinational):**
  - `a_busy_o = cpu_reset_i | flush_i | !slot_free | (a_vld_i & winner==B)`.
  - `b_busy_o` is the symmetric expression.
  - A requester with valid=0 can still see busy=1; that is harmless.
- **On accept:** the winner's fields load into the `lsu_*_o` register, `lsu_vld_o`←1 and `grant_b_o`←(winner==B).
- **Slot free, no winner:** `lsu_vld_o`←0 and the other fields hold their values.
- **Slot not free:** all `lsu_*_o` and `grant_b_o` hold their values.
- **Starvation counter `starve_q`** (4 bits):
  - Increments on a B grant while `a_vld_i`=1.
  - Clears on an A grant, or in any cycle with `a_vld_i`=0.
  - Saturates at `STARVE_LIMIT`.
- **FSM:**
  - NORMAL→FORCE_A when `starve_q` would reach `STARVE_LIMIT`.
  - FORCE_A→NORMAL on an A grant, on `a_vld_i`=0, or on flush.
- **Flush:**
  - Next cycle: `lsu_vld_o`=0 and `grant_b_o`=0, regardless of `agu_busy_i`. AGU0 flushes its own skid buffer in the same cycle.
  - `starve_q`=0 and state returns to NORMAL.
  - Nothing is granted in the flush cycle.
- **Store/load:** both are handled identically; the arbiter never inspects `op` beyond passing it through.

## Timing
- **Reset (asynchronous):** `lsu_vld_o`=0, `grant_b_o`=0, `starve_q`=0, state NORMAL. All other `lsu_*_o` = 0. `a_busy_o`=`b_busy_o`=1 while reset is asserted.
- **Latency:** 1 cycle from an accepted request to `lsu_vld_o`.
- **Throughput:** 1 request per cycle when `agu_busy_i`=0.
- **Stability:** while `lsu_vld_o`=1 and `agu_busy_i`=1, every `lsu_*_o` is bit-stable.
- **Back-pressure:** `agu_busy_i` rising in the same cycle as an accept is not a conflict. The slot was free by definition, so the request is registered and then held.
- **Flush vs. accept:** simultaneous `flush_i` and a request means `flush_i` wins and the request is dropped.
- **Reset released mid-stream:** the first grant can happen in the first cycle with `cpu_reset_i`=0.

## Structure
- **Shared package `agu_pkg`:**
  - `agu_req_t` packed struct `{rob[5:0], op[3:0], data[31:0], addr[31:0], dest[5:0]}`, 80 bits, same ordering as AGU0's skid buffer.
  - `OP_STORE_BIT`=3.
  - `arb_state_e` {NORMAL, FORCE_A}.
- **Sub-module:** one natural sub-module, `agu_arb_starve`, containing the counter, the FSM and the winner select; it outputs `sel_b` and `sel_vld`. The top level holds the output register and the busy logic.

## Test plan
- **Simple A and B issue:**
  - A only, `a_vld_i`=1, addr 0x1000, `agu_busy_i`=0 → next cycle `lsu_vld_o`=1, `lsu_addr_o`=0x1000, `grant_b_o`=0, `a_busy_o`=0.
  - A and B both valid in NORMAL → B issued, `a_busy_o`=1, `b_busy_o`=0, A is issued the cycle after B drops.
- **Starvation:** A and B held continuously, `STARVE_LIMIT`=4 → grant sequence B,B,B,B,A,B,B,B,B,A…; `starve_q` never exceeds 4.
- **Back-pressure:** `agu_busy_i`=1 for 3 cycles with `lsu_vld_o`=1 → outputs bit-stable, both busy=1; on release the held request retires and a new grant loads in the same cycle.
- **Flush:**
  - `flush_i` with `lsu_vld_o`=1, `agu_busy_i`=1 → next cycle `lsu_vld_o`=0, state NORMAL, `starve_q`=0.
  - A request presented in the flush cycle is not issued.
- **Asynchronous reset mid-hold:** assert `cpu_reset_i` between clock edges → `lsu_vld_o`=0 and both busy=1 immediately; first grant on the first edge after release.
